// File: rtl/gpio_loop_tester_if.sv
// Register-file side of the GPIO loopback tester: run control in, results out.
// The pin-side pattern/loopback buses stay as plain ports on the tester.
interface gpio_loop_tester_if #(
  parameter int WIDTH = 12
);
  localparam int STEP_W = $clog2(2 * WIDTH) + 1;

  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic              pass;
  logic [WIDTH-1:0]  fail_mask;
  logic [15:0]       err_count;
  logic              first_fail_valid;
  logic [STEP_W-1:0] first_fail_step;

  modport master (
    output start, mode,
    input  busy, done, pass, fail_mask, err_count, first_fail_valid, first_fail_step
  );

  modport slave (
    input  start, mode,
    output busy, done, pass, fail_mask, err_count, first_fail_valid, first_fail_step
  );
endinterface

// File: rtl/gpio_loop_tester.sv
// Self-running continuity tester for looped-back GPIO pairs: walks a one and/or a
// zero across gp_out, compares the synchronised gp_in and accumulates per-bit failures.
module gpio_loop_tester #(
  parameter int WIDTH       = 12,
  parameter int SETTLE      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  gpio_loop_tester_if.slave ctl,
  output logic [WIDTH-1:0]  gp_out,
  input  logic [WIDTH-1:0]  gp_in
);

  localparam int STEP_W = $clog2(2 * WIDTH) + 1;
  localparam int CNT_W  = $clog2(SETTLE + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  gp_out_q, gp_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [WIDTH-1:0]  fail_mask_q, fail_mask_d;
  logic [15:0]       err_count_q, err_count_d;
  logic              ffv_q, ffv_d;
  logic [STEP_W-1:0] ffs_q, ffs_d;

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  gp_sync;
  logic [WIDTH-1:0]  mis;
  logic [STEP_W-1:0] last_step;

  // Walk-1 sets bit s; walk-0 clears it. Steps past WIDTH are the walk-0 half of mode 1x.
  function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m, input logic [STEP_W-1:0] s);
    logic [WIDTH-1:0] one_hot;
    int               bit_idx;
    logic             walk0;
    bit_idx = int'(s);
    walk0   = (m == 2'b01);
    if (bit_idx >= WIDTH) begin
      bit_idx = bit_idx - WIDTH;
      walk0   = 1'b1;
    end
    one_hot    = '0;
    one_hot[0] = 1'b1;
    one_hot    = one_hot << bit_idx;
    return walk0 ? ~one_hot : one_hot;
  endfunction

  // gp_in is asynchronous to clk; only the last stage is ever looked at.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gp_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gp_sync   = sync_q[SYNC_STAGES-1];
  // gp_out_q holds pattern(step_q) for the whole hold window, so it is the compare reference.
  assign mis       = gp_sync ^ gp_out_q;
  assign last_step = mode_q[1] ? STEP_W'(2 * WIDTH - 1) : STEP_W'(WIDTH - 1);

  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_d     = state_q;
    mode_d      = mode_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    gp_out_d    = gp_out_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    err_count_d = err_count_q;
    ffv_d       = ffv_q;
    ffs_d       = ffs_q;

    unique case (state_q)
      IDLE, DONE: begin
        gp_out_d = '0;
        busy_d   = 1'b0;
        if (ctl.start) begin
          mode_d      = ctl.mode;
          step_d      = '0;
          cnt_d       = CNT_W'(SETTLE + 1);
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_mask_d = '0;
          err_count_d = '0;
          ffv_d       = 1'b0;
          ffs_d       = '0;
          state_d     = RUN;
        end
      end

      RUN: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          // First RUN cycle loads step 0 onto the pins; later ones just hold it.
          cnt_d    = cnt_q - CNT_W'(1);
          gp_out_d = pattern(mode_q, step_q);
        end else begin
          fail_mask_d = fail_mask_q | mis;
          if (mis != '0) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffs_d = step_q;
            end
          end
          if (step_q == last_step) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            gp_out_d = '0;
            done_d   = 1'b1;
            pass_d   = (fail_mask_d == '0);
          end else begin
            // Next pattern goes out on this same edge: no idle gap between steps.
            step_d   = step_q + STEP_W'(1);
            cnt_d    = CNT_W'(SETTLE);
            gp_out_d = pattern(mode_q, step_d);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      gp_out_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      err_count_q <= '0;
      ffv_q       <= 1'b0;
      ffs_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      gp_out_q    <= gp_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      err_count_q <= err_count_d;
      ffv_q       <= ffv_d;
      ffs_q       <= ffs_d;
    end
  end

  assign gp_out               = gp_out_q;
  assign ctl.busy             = busy_q;
  assign ctl.done             = done_q;
  assign ctl.pass             = pass_q;
  assign ctl.fail_mask        = fail_mask_q;
  assign ctl.err_count        = err_count_q;
  assign ctl.first_fail_valid = ffv_q;
  assign ctl.first_fail_step  = ffs_q;

endmodule
